// File: rtl/parking_display_driver.sv
// Converts the binary parking count to BCD with a bit-serial shift-add-3 engine and
// scans the four digits onto an active-low multiplexed seven-segment display.
`timescale 1ns/1ps
module parking_display_driver #(
  parameter int CNT_W       = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_LZ    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] count,
  output logic [6:0]       seg,
  output logic [3:0]       an,
  output logic [15:0]      bcd,
  output logic             busy
);

  localparam int SW = 16 + CNT_W;
  localparam int IW = $clog2(CNT_W + 1);
  localparam int PW = $clog2(REFRESH_DIV);

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  state_t           state;
  logic [CNT_W-1:0] cap;
  logic [SW-1:0]    sh;
  logic [SW-1:0]    adj;
  logic [IW-1:0]    iter;

  // Add 3 to every BCD nibble that would overflow past 9 when doubled.
  assign adj[CNT_W-1:0] = sh[CNT_W-1:0];
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_adj
      logic [3:0] nib;
      assign nib = sh[CNT_W + 4*gi +: 4];
      assign adj[CNT_W + 4*gi +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cap   <= '0;
      sh    <= '0;
      iter  <= '0;
      bcd   <= 16'h0000;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (count != cap) begin
            cap   <= count;
            sh    <= {16'b0, count};
            iter  <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          sh   <= SW'({adj, 1'b0});
          iter <= iter + 1'b1;
          if (iter == IW'(CNT_W - 1))
            state <= LOAD;
        end
        LOAD: begin
          // bcd only ever changes here, so partial results never reach the display.
          bcd   <= sh[SW-1:CNT_W];
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  logic [PW-1:0] pre;
  logic [1:0]    idx;
  logic [1:0]    idx_next;
  logic          wrap;
  logic          lead_zero;
  logic          blank;

  assign wrap     = (pre == PW'(REFRESH_DIV - 1));
  assign idx_next = wrap ? idx + 2'd1 : idx;

  // lead_zero: the digit about to be shown and every digit above it are zero.
  always_comb begin
    lead_zero = 1'b0;
    case (idx_next)
      2'd1:    lead_zero = (bcd[15:4] == 12'd0);
      2'd2:    lead_zero = (bcd[15:8] == 8'd0);
      2'd3:    lead_zero = (bcd[15:12] == 4'd0);
      default: lead_zero = 1'b0;
    endcase
  end

  assign blank = (BLANK_LZ != 0) && lead_zero;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre <= '0;
      idx <= 2'd0;
      an  <= 4'b1110;
      seg <= 7'b1000000;
    end else begin
      pre <= wrap ? '0 : pre + 1'b1;
      idx <= idx_next;
      an  <= blank ? 4'b1111 : ~(4'b0001 << idx_next);
      seg <= blank ? 7'b1111111 : seg_decode(bcd[4*idx_next +: 4]);
    end
  end

endmodule

// File: tb/tb_parking_display_driver.sv
// Scoreboard bench for parking_display_driver: two instances (blanking on/off) share
// stimulus; expected BCD results are queued on each count change and popped at LOAD.
`timescale 1ns/1ps
module tb_parking_display_driver;
  localparam int CNT_W = 8;
  localparam int RDIV  = 4;

  logic             clk   = 1'b0;
  logic             reset = 1'b1;
  logic [CNT_W-1:0] count = '0;
  logic [6:0]       seg, seg2;
  logic [3:0]       an, an2;
  logic [15:0]      bcd, bcd2;
  logic             busy, busy2;

  always #5 clk = ~clk;

  parking_display_driver #(.CNT_W(CNT_W), .REFRESH_DIV(RDIV), .BLANK_LZ(1)) dut (
    .clk(clk), .reset(reset), .count(count), .seg(seg), .an(an), .bcd(bcd), .busy(busy));

  parking_display_driver #(.CNT_W(CNT_W), .REFRESH_DIV(RDIV), .BLANK_LZ(0)) dut_nb (
    .clk(clk), .reset(reset), .count(count), .seg(seg2), .an(an2), .bcd(bcd2), .busy(busy2));

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_q[$];
  int          last_set = 0;

  // Independent model of the scan position: digit advances every RDIV clocks.
  int m_pre = 0;
  int m_idx = 0;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pre <= 0;
      m_idx <= 0;
    end else if (m_pre == RDIV - 1) begin
      m_pre <= 0;
      m_idx <= (m_idx + 1) % 4;
    end else begin
      m_pre <= m_pre + 1;
    end
  end

  function automatic logic [15:0] to_bcd(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Scoreboard monitor: bcd may only change on the cycle busy falls.
  logic        prev_busy = 1'b0;
  logic [15:0] prev_bcd  = 16'h0000;
  logic [15:0] sb_exp;
  always @(negedge clk) begin
    if (reset) begin
      prev_busy = 1'b0;
      prev_bcd  = bcd;
    end else begin
      if (prev_busy && !busy) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected_load: bcd=%h but no result was queued", bcd);
        end else begin
          sb_exp = exp_q.pop_front();
          if (bcd !== sb_exp) begin
            n_fail++;
            $display("FAIL sb_load: bcd=%h expected %h", bcd, sb_exp);
          end else begin
            $display("load bcd=%h expected %h ok", bcd, sb_exp);
          end
        end
      end else if (bcd !== prev_bcd) begin
        n_checks++;
        n_fail++;
        $display("FAIL bcd_glitch: bcd changed %h -> %h outside LOAD", prev_bcd, bcd);
      end
      prev_busy = busy;
      prev_bcd  = bcd;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_count(input int v);
    count = CNT_W'(v);
    if (v != last_set) exp_q.push_back(to_bcd(v));
    last_set = v;
    $display("drive count=%0d", v);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL wait_done: %0d results still pending, required 0", exp_q.size());
    end
    repeat (2) tick();
  endtask

  task automatic check_scan(input int val, input int cycles);
    int          k;
    logic [15:0] b;
    logic [3:0]  d;
    logic        blank;
    logic [3:0]  e_an, e_an2;
    logic [6:0]  e_seg, e_seg2;
    int          errs;
    errs = 0;
    b = to_bcd(val);
    for (int c = 0; c < cycles; c++) begin
      tick();
      k      = m_idx;
      d      = b[4*k +: 4];
      blank  = (k > 0) && (val < 10 ** k);
      e_an2  = ~(4'b0001 << k);
      e_seg2 = seg_of(d);
      e_an   = blank ? 4'b1111 : e_an2;
      e_seg  = blank ? 7'b1111111 : e_seg2;
      n_checks += 4;
      if (an !== e_an) begin
        n_fail++; errs++;
        $display("FAIL scan_an: val=%0d digit=%0d an=%b expected %b", val, k, an, e_an);
      end
      if (seg !== e_seg) begin
        n_fail++; errs++;
        $display("FAIL scan_seg: val=%0d digit=%0d seg=%b expected %b", val, k, seg, e_seg);
      end
      if (an2 !== e_an2) begin
        n_fail++; errs++;
        $display("FAIL scan_an_noblank: val=%0d digit=%0d an=%b expected %b", val, k, an2, e_an2);
      end
      if (seg2 !== e_seg2) begin
        n_fail++; errs++;
        $display("FAIL scan_seg_noblank: val=%0d digit=%0d seg=%b expected %b", val, k, seg2, e_seg2);
      end
    end
    $display("scan val=%0d over %0d cycles, %0d errors", val, cycles, errs);
  endtask

  task automatic check_reset_values(input string tag);
    n_checks += 5;
    if (bcd !== 16'h0000) begin n_fail++; $display("FAIL %s_bcd: %h expected 0000", tag, bcd); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_busy: %b expected 0", tag, busy); end
    if (an !== 4'b1110) begin n_fail++; $display("FAIL %s_an: %b expected 1110", tag, an); end
    if (seg !== 7'b1000000) begin n_fail++; $display("FAIL %s_seg: %b expected 1000000", tag, seg); end
    if (bcd2 !== 16'h0000) begin n_fail++; $display("FAIL %s_bcd_noblank: %h expected 0000", tag, bcd2); end
    $display("%s reset values checked", tag);
  endtask

  // Expects busy high for CNT_W+1 edges and the result on the following edge.
  task automatic check_latency(input logic [15:0] old_bcd, input logic [15:0] new_bcd, input string tag);
    for (int i = 0; i <= CNT_W; i++) begin
      tick();
      n_checks += 2;
      if (busy !== 1'b1) begin
        n_fail++; $display("FAIL %s_busy_hi: edge %0d busy=%b expected 1", tag, i + 1, busy);
      end
      if (bcd !== old_bcd) begin
        n_fail++; $display("FAIL %s_bcd_hold: edge %0d bcd=%h expected %h", tag, i + 1, bcd, old_bcd);
      end
    end
    tick();
    n_checks += 2;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL %s_busy_lo: busy=%b expected 0", tag, busy);
    end
    if (bcd !== new_bcd) begin
      n_fail++; $display("FAIL %s_bcd_valid: bcd=%h expected %h", tag, bcd, new_bcd);
    end
    $display("%s latency checked, bcd=%h", tag, bcd);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    count = '0;
    repeat (2) tick();
    check_reset_values("reset");
    @(posedge clk);
    #1 reset = 1'b0;
    check_scan(0, 16);
  endtask

  task automatic test_convert_137();
    set_count(137);
    check_latency(16'h0000, 16'h0137, "conv137");
    tick();
    check_scan(137, 16);
  endtask

  task automatic test_back_to_back();
    set_count(255);
    repeat (3) tick();
    set_count(254);
    wait_done();
    n_checks++;
    if (bcd !== 16'h0254) begin
      n_fail++; $display("FAIL b2b_final: bcd=%h expected 0254", bcd);
    end
    check_scan(254, 16);
  endtask

  task automatic test_blanking_ten();
    set_count(10);
    wait_done();
    n_checks++;
    if (bcd !== 16'h0010) begin
      n_fail++; $display("FAIL ten_bcd: bcd=%h expected 0010", bcd);
    end
    check_scan(10, 16);
  endtask

  task automatic test_reset_mid();
    set_count(200);
    repeat (3) tick();
    reset = 1'b1;
    #1;
    check_reset_values("midreset");
    @(posedge clk);
    #1 reset = 1'b0;
    check_latency(16'h0000, 16'h0200, "restart200");
    tick();
    check_scan(200, 16);
  endtask

  task automatic test_hold_9();
    int errs;
    errs = 0;
    set_count(9);
    wait_done();
    for (int i = 0; i < 100; i++) begin
      tick();
      n_checks++;
      if (busy !== 1'b0 || bcd !== 16'h0009) begin
        n_fail++; errs++;
        $display("FAIL hold_idle: cycle %0d busy=%b bcd=%h expected busy 0 bcd 0009", i, busy, bcd);
      end
    end
    $display("hold count=9 for 100 cycles, %0d errors", errs);
    check_scan(9, 32);
  endtask

  initial begin
    test_reset();
    test_convert_137();
    test_back_to_back();
    test_blanking_ten();
    test_reset_mid();
    test_hold_9();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d results never produced, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
